sqrt_jk_array: RTL and testbench

Multi-channel stochastic square-root unit for the unipolar bit-stream datapath. Each of `CH` channels applies the JK-flip-flop feedback square-root: the output is the input bit when the channel's JK state is 1, and forced 1 when it is 0. For an independent Bernoulli input with probability p, the output stream has ideal mean 2p/(1+p). A shared window counter and per-channel ones-accumulators (optional) convert the output streams back to binary counts for checking and downstream use.

---
 rtl/sqrt_jk_array.sv | 100 ++++++++++
 tb/tb_sqrt_jk_array.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sqrt_jk_array.sv
// Multi-channel stochastic square-root unit using JK-flip-flop feedback.
// Define SQRT_JK_ACC_EN to build the window counter and per-channel ones-accumulators.
module sqrt_jk_array #(
  parameter int   CH      = 4,
  parameter int   WIN_W   = 8,
  parameter logic JK_INIT = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic [CH-1:0]             in,
  output logic [CH-1:0]             out,
  output logic [CH*(WIN_W+1)-1:0]   acc,
  output logic                      acc_valid
);

  logic [CH-1:0] r_jk;
  logic [CH-1:0] w_out;
  logic [CH-1:0] w_jk_nxt;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_out    = '0;
    w_jk_nxt = '0;
    for (int c = 0; c < CH; c++) begin
      w_out[c]    = en ? (r_jk[c] ? in[c] : 1'b1) : 1'b0;
      // J tied high, K = out: toggle when the output fires, otherwise set.
      w_jk_nxt[c] = w_out[c] ? ~r_jk[c] : 1'b1;
    end
  end

  assign out = w_out;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jk <= {CH{JK_INIT}};
    end else if (clr) begin
      r_jk <= {CH{JK_INIT}};
    end else if (en) begin
      r_jk <= w_jk_nxt;
    end
  end

`ifdef SQRT_JK_ACC_EN
  logic [WIN_W-1:0]           r_win_cnt;
  logic [WIN_W-1:0]           r_ones [CH];
  logic [CH*(WIN_W+1)-1:0]    r_acc;
  logic                       r_acc_valid;
  logic                       w_win_last;
  logic [WIN_W:0]             w_ones_sum [CH];
  logic [WIN_W-1:0]           w_ones_inc [CH];

  assign w_win_last = (r_win_cnt == {WIN_W{1'b1}});

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      w_ones_sum[c] = {1'b0, r_ones[c]} + {{WIN_W{1'b0}}, w_out[c]};
      w_ones_inc[c] = w_ones_sum[c][WIN_W-1:0];
    end
  end

  // NOTE: the ones array is small flop storage, not a RAM, so it takes the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt   <= '0;
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
      for (int c = 0; c < CH; c++) r_ones[c] <= '0;
    end else if (clr) begin
      r_win_cnt   <= '0;
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
      for (int c = 0; c < CH; c++) r_ones[c] <= '0;
    end else begin
      // Pulse lasts exactly one cycle; window-last can never occur twice in a row.
      r_acc_valid <= en && w_win_last;
      if (en) begin
        r_win_cnt <= r_win_cnt + 1'b1;
        for (int c = 0; c < CH; c++) begin
          if (w_win_last) begin
            r_ones[c]                      <= '0;
            r_acc[c*(WIN_W+1) +: WIN_W+1]  <= w_ones_sum[c];
          end else begin
            r_ones[c] <= w_ones_inc[c];
          end
        end
      end
    end
  end

  assign acc       = r_acc;
  assign acc_valid = r_acc_valid;
`else
  assign acc       = '0;
  assign acc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_jk_array.sv
// Directed self-checking bench for sqrt_jk_array (CH=2, WIN_W=4, JK_INIT=0).
// Accumulator expectations collapse to zero when SQRT_JK_ACC_EN is undefined.
module tb_sqrt_jk_array;

  localparam int CH    = 2;
  localparam int WIN_W = 4;
  localparam int AW    = CH * (WIN_W + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          clr;
  logic [CH-1:0] in;
  logic [CH-1:0] out;
  logic [AW-1:0] acc;
  logic          acc_valid;

  int n_cmp = 0;
  int n_err = 0;

  sqrt_jk_array #(.CH(CH), .WIN_W(WIN_W), .JK_INIT(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .in        (in),
    .out       (out),
    .acc       (acc),
    .acc_valid (acc_valid)
  );

  always #5 clk = ~clk;

  localparam logic [AW-1:0] ACC_16_16 = {5'd16, 5'd16};
  localparam logic [AW-1:0] ACC_1_1   = {5'd1,  5'd1};
  localparam logic [AW-1:0] ACC_16_15 = {5'd16, 5'd15};

  function automatic logic [AW-1:0] ea(input logic [AW-1:0] v);
`ifdef SQRT_JK_ACC_EN
    return v;
`else
    return '0;
`endif
  endfunction

  function automatic logic eav(input logic v);
`ifdef SQRT_JK_ACC_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive in=00 briefly to expose the JK state through out (out = ~jk when en=1).
  task automatic probe_jk(input string tag, input logic [CH-1:0] exp_out);
    logic [CH-1:0] saved;
    saved = in;
    in = '0;
    #1;
    check(tag, 32'(out), 32'(exp_out));
    in = saved;
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_acc", 32'(acc), 32'(0));
    check("clr_av", 32'(acc_valid), 32'(0));
  endtask

  // n enabled cycles of constant out; acc_valid expected only after the last one when pulse_at_end.
  task automatic run_const(input string tag, input int n, input logic [CH-1:0] exp_out, input logic pulse_at_end);
    for (int k = 0; k < n; k++) begin
      check({tag, "_out"}, 32'(out), 32'(exp_out));
      tick();
      check({tag, "_av"}, 32'(acc_valid), 32'(eav(pulse_at_end && k == n - 1)));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    in    = '0;
    #3;
    check("rst_out_dis", 32'(out), 32'(0));
    check("rst_acc", 32'(acc), 32'(0));
    check("rst_av", 32'(acc_valid), 32'(0));
    en = 1'b1;
    in = 2'b11;
    #1;
    check("rst_out_en", 32'(out), 32'(2'b11));
    @(negedge clk);
    rst_n = 1'b1;

    // All-ones input: output always 1, full window counts 16.
    run_const("ones", 16, 2'b11, 1'b1);
    check("ones_acc", 32'(acc), 32'(ea(ACC_16_16)));
    run_const("ones_post", 2, 2'b11, 1'b0);
    check("ones_acc_hold", 32'(acc), 32'(ea(ACC_16_16)));

    // All-zeros input: only the first cycle fires, then jk sticks at 1.
    do_clr();
    in = 2'b00;
    check("zero_out_first", 32'(out), 32'(2'b11));
    tick();
    check("zero_av_first", 32'(acc_valid), 32'(0));
    run_const("zero", 15, 2'b00, 1'b1);
    check("zero_acc1", 32'(acc), 32'(ea(ACC_1_1)));
    run_const("zero2", 16, 2'b00, 1'b1);
    check("zero_acc2", 32'(acc), 32'(ea('0)));

    // Alternating ch0 input starting with 1; ch1 held at 1.
    do_clr();
    for (int k = 0; k < 16; k++) begin
      in = {1'b1, (k % 2 == 0)};
      #1;
      check("alt_out", 32'(out), 32'((k == 1) ? 2'b10 : 2'b11));
      tick();
      check("alt_av", 32'(acc_valid), 32'(eav(k == 15)));
    end
    check("alt_acc", 32'(acc), 32'(ea(ACC_16_15)));

    // Enable gap of 5 cycles mid-window stretches the window.
    do_clr();
    in = 2'b11;
    run_const("gap_a", 6, 2'b11, 1'b0);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("gap_out", 32'(out), 32'(0));
      tick();
      check("gap_av", 32'(acc_valid), 32'(0));
      check("gap_acc", 32'(acc), 32'(0));
    end
    en = 1'b1;
    #1;
    run_const("gap_b", 10, 2'b11, 1'b1);
    check("gap_acc_end", 32'(acc), 32'(ea(ACC_16_16)));

    // clr at enabled cycle 7 discards the partial window and clears jk.
    do_clr();
    in = 2'b11;
    run_const("mid", 7, 2'b11, 1'b0);
    probe_jk("mid_jk_before", 2'b00);
    do_clr();
    probe_jk("mid_jk_after_clr", 2'b11);
    run_const("mid_win", 16, 2'b11, 1'b1);
    check("mid_acc", 32'(acc), 32'(ea(ACC_16_16)));
    run_const("mid_pre_rst", 4, 2'b11, 1'b0);

    // Asynchronous reset mid-window takes effect immediately.
    rst_n = 1'b0;
    #2;
    check("arst_acc", 32'(acc), 32'(0));
    check("arst_av", 32'(acc_valid), 32'(0));
    probe_jk("arst_jk", 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    run_const("arst_win", 16, 2'b11, 1'b1);
    check("arst_acc_end", 32'(acc), 32'(ea(ACC_16_16)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
